// File: rtl/board_io_bridge.sv
// board_io_bridge: polarity-corrected, synchronised and debounced bridge between SoC virtual I/O and board pins,
// with static or time-multiplexed seven-segment drive.
module board_io_bridge #(
   parameter int N_LED           = 36,
   parameter int N_SW            = 36,
   parameter int N_BTN           = 20,
   parameter int N_PHYS_SW       = 18,
   parameter int N_PHYS_BTN      = 4,
   parameter int N_HEX           = 8,
   parameter bit HEX_MUXED       = 1'b0,
   parameter bit BTN_REL_LEVEL   = 1'b1,
   parameter bit SEG_ON_LEVEL    = 1'b0,
   parameter bit DIG_ON_LEVEL    = 1'b0,
   parameter bit LED_DARK_LEVEL  = 1'b0,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SCAN_CYCLES     = 10000
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [N_PHYS_SW-1:0]  phys_sw,
   input  logic [N_PHYS_BTN-1:0] phys_btn,
   output logic [N_LED-1:0]      phys_led,
   output logic [N_HEX*7-1:0]    phys_hex,
   output logic [7:0]            scan_seg,
   output logic [N_HEX-1:0]      scan_dig,
   output logic [N_SW-1:0]       vSWITCH,
   output logic [N_BTN-1:0]      vBUTTON,
   output logic [N_BTN-1:0]      vBUTTON_PRESS,
   input  logic [N_LED-1:0]      vLED,
   input  logic [N_HEX*8-1:0]    vSSLED
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = $clog2(SCAN_CYCLES);
   localparam int IW = N_HEX > 1 ? $clog2(N_HEX) : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [IW-1:0] HEX_LAST  = IW'(N_HEX - 1);

   logic [N_PHYS_SW-1:0]  sw_s1, sw_s2;
   logic [N_PHYS_BTN-1:0] btn_s1, btn_s2, btn_raw, btn_q, btn_press;
   logic [DW-1:0]         db_cnt [N_PHYS_BTN];
   logic                  unused_dp;

   assign btn_raw   = btn_s2 ^ {N_PHYS_BTN{BTN_REL_LEVEL}};
   assign unused_dp = ^vSSLED;

   always_comb begin
      vSWITCH                          = '0;
      vSWITCH[N_PHYS_SW-1:0]           = sw_s2;
      vBUTTON                          = '0;
      vBUTTON[N_PHYS_BTN-1:0]          = btn_q;
      vBUTTON_PRESS                    = '0;
      vBUTTON_PRESS[N_PHYS_BTN-1:0]    = btn_press;
   end

   // a button flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         sw_s1     <= '0;
         sw_s2     <= '0;
         btn_s1    <= '0;
         btn_s2    <= '0;
         btn_q     <= '0;
         btn_press <= '0;
         phys_led  <= {N_LED{LED_DARK_LEVEL}};
         for (int i = 0; i < N_PHYS_BTN; i++) db_cnt[i] <= '0;
      end else begin
         sw_s1     <= phys_sw;
         sw_s2     <= sw_s1;
         btn_s1    <= phys_btn;
         btn_s2    <= btn_s1;
         btn_press <= '0;
         phys_led  <= vLED ^ {N_LED{LED_DARK_LEVEL}};
         for (int i = 0; i < N_PHYS_BTN; i++) begin
            if (btn_raw[i] == btn_q[i]) db_cnt[i] <= '0;
            else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]    <= '0;
               btn_q[i]     <= ~btn_q[i];
               btn_press[i] <= ~btn_q[i];
            end else db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   if (HEX_MUXED) begin : g_scan
      logic [CW-1:0] slot;
      logic [IW-1:0] idx;
      assign phys_hex = {N_HEX*7{~SEG_ON_LEVEL}};
      // slot cycle 0 is blanked so the previous digit's segments never leak into the next
      always_ff @(posedge CLK) begin
         if (!RESET_N) begin
            slot     <= '0;
            idx      <= '0;
            scan_seg <= {8{~SEG_ON_LEVEL}};
            scan_dig <= {N_HEX{~DIG_ON_LEVEL}};
         end else begin
            slot     <= slot == SCAN_LAST ? '0 : slot + 1'b1;
            idx      <= slot != SCAN_LAST ? idx : idx == HEX_LAST ? '0 : idx + 1'b1;
            scan_seg <= slot == '0 ? {8{~SEG_ON_LEVEL}} : vSSLED[{idx, 3'b000} +: 8] ^ {8{~SEG_ON_LEVEL}};
            scan_dig <= slot == '0 ? {N_HEX{~DIG_ON_LEVEL}} : {N_HEX{~DIG_ON_LEVEL}} ^ (N_HEX'(1) << idx);
         end
      end
   end else begin : g_static
      assign scan_seg = {8{~SEG_ON_LEVEL}};
      assign scan_dig = {N_HEX{~DIG_ON_LEVEL}};
      always_ff @(posedge CLK)
         for (int d = 0; d < N_HEX; d++)
            phys_hex[7*d +: 7] <= RESET_N ? vSSLED[8*d +: 7] ^ {7{~SEG_ON_LEVEL}} : {7{~SEG_ON_LEVEL}};
   end
endmodule

// File: tb/tb_board_io_bridge.sv
// tb_board_io_bridge: scoreboarded directed test of a static-hex bridge (a) and a scanned, dark-high bridge (b).
module tb_board_io_bridge;
   logic        clk = 0;
   logic        rst_a_n, rst_b_n;
   logic [17:0] sw_a, sw_b;
   logic [3:0]  btn_a, btn_b;
   logic [35:0] vled_a, vled_b, led_a, led_b, vsw_a, vsw_b;
   logic [31:0] vss_a, vss_b;
   logic [27:0] hex_a, hex_b;
   logic [7:0]  seg_a, seg_b;
   logic [3:0]  dig_a, dig_b;
   logic [19:0] vbtn_a, vbtn_b, vpr_a, vpr_b;

   board_io_bridge #(.N_HEX(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut_a (
      .CLK(clk), .RESET_N(rst_a_n), .phys_sw(sw_a), .phys_btn(btn_a), .phys_led(led_a),
      .phys_hex(hex_a), .scan_seg(seg_a), .scan_dig(dig_a), .vSWITCH(vsw_a), .vBUTTON(vbtn_a),
      .vBUTTON_PRESS(vpr_a), .vLED(vled_a), .vSSLED(vss_a));

   board_io_bridge #(.N_HEX(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3), .HEX_MUXED(1'b1),
                     .LED_DARK_LEVEL(1'b1)) dut_b (
      .CLK(clk), .RESET_N(rst_b_n), .phys_sw(sw_b), .phys_btn(btn_b), .phys_led(led_b),
      .phys_hex(hex_b), .scan_seg(seg_b), .scan_dig(dig_b), .vSWITCH(vsw_b), .vBUTTON(vbtn_b),
      .vBUTTON_PRESS(vpr_b), .vLED(vled_b), .vSSLED(vss_b));

   always #5 clk = ~clk;

   typedef enum int {A_LED, A_HEX, A_BTN, A_SW, A_DIG, B_LED, B_HEX, B_DIG, B_SEG} sig_t;
   typedef struct {int cyc; sig_t id; logic [63:0] exp;} chk_t;

   chk_t sb[$];
   int   pq[$];
   int   cyc = 0, checks = 0, errors = 0, r, m;
   logic [7:0] seg_tab [4] = '{8'hC0, 8'hB0, 8'hA4, 8'hF9};
   logic [3:0] dig_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] probe(sig_t id);
      case (id)
         A_LED:   return 64'(led_a);
         A_HEX:   return 64'(hex_a);
         A_BTN:   return 64'(vbtn_a);
         A_SW:    return 64'(vsw_a);
         A_DIG:   return 64'(dig_a);
         B_LED:   return 64'(led_b);
         B_HEX:   return 64'(hex_b);
         B_DIG:   return 64'(dig_b);
         default: return 64'(seg_b);
      endcase
   endfunction

   task automatic expect_at(int c, sig_t id, logic [63:0] v);
      sb.push_back('{c, id, v});
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // scoreboard monitor: retires every entry due at this cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].cyc <= cyc) begin
            checks++;
            if (sb[i].cyc < cyc || probe(sb[i].id) !== sb[i].exp) begin
               errors++;
               $display("FAIL %s due %0d at %0d got %h exp %h", sb[i].id.name(), sb[i].cyc, cyc,
                        probe(sb[i].id), sb[i].exp);
            end
            sb.delete(i);
         end
   end

   // press monitor: every pulse must match a queued expectation
   always @(negedge clk)
      if (vpr_a !== '0) begin
         checks++;
         if (pq.size() == 0 || pq[0] != cyc || vpr_a !== 20'h1) begin
            errors++;
            $display("FAIL press at %0d got %h exp %0d", cyc, vpr_a, pq.size() ? pq[0] : -1);
         end
         if (pq.size()) void'(pq.pop_front());
      end

   initial begin
      rst_a_n = 0; rst_b_n = 0;
      sw_a = '0; sw_b = '0; btn_a = 4'hF; btn_b = 4'hF;
      vled_a = '0; vled_b = '0; vss_a = '0; vss_b = '0;
      step(2);
      expect_at(cyc, A_LED, 64'h0);
      expect_at(cyc, A_HEX, 64'hFFFFFFF);
      expect_at(cyc, A_BTN, 64'h0);
      expect_at(cyc, A_SW, 64'h0);
      expect_at(cyc, A_DIG, 64'hF);
      expect_at(cyc, B_LED, 64'hFFFFFFFFF);
      expect_at(cyc, B_DIG, 64'hF);
      expect_at(cyc, B_SEG, 64'hFF);
      rst_a_n = 1;
      vled_a  = 36'h0A5;
      vss_a   = {8'h06, 8'h5B, 8'h4F, 8'h3F};
      expect_at(cyc + 1, A_LED, 64'h0A5);
      expect_at(cyc + 1, A_HEX, 64'({7'h79, 7'h24, 7'h30, 7'h40}));
      expect_at(cyc + 2, A_DIG, 64'hF);
      step(4);
      sw_a[17] = 1'b1;
      expect_at(cyc + 1, A_SW, 64'h0);
      expect_at(cyc + 2, A_SW, 64'h20000);
      expect_at(cyc + 4, A_SW, 64'h20000);
      step(4);
      btn_a[0] = 1'b0;
      step(2);
      btn_a[0] = 1'b1;
      step(1);
      btn_a[0] = 1'b0;
      m = cyc;
      expect_at(m + 1, A_BTN, 64'h0);
      expect_at(m + 5, A_BTN, 64'h0);
      expect_at(m + 6, A_BTN, 64'h1);
      expect_at(m + 9, A_BTN, 64'h1);
      pq.push_back(m + 6);
      step(12);
      btn_a[0] = 1'b1;
      m = cyc;
      expect_at(m + 5, A_BTN, 64'h1);
      expect_at(m + 6, A_BTN, 64'h0);
      step(10);
      r = cyc;
      rst_b_n = 1;
      vled_b  = 36'h0A5;
      vss_b   = {8'h06, 8'h5B, 8'h4F, 8'h3F};
      expect_at(r + 1, B_LED, 64'hFFFFFFF5A);
      expect_at(r + 1, B_HEX, 64'hFFFFFFF);
      for (int j = 0; j < 20; j++) begin
         expect_at(r + 1 + j, B_DIG, 64'(j % 3 == 0 ? 4'hF : dig_tab[(j / 3) % 4]));
         expect_at(r + 1 + j, B_SEG, 64'(j % 3 == 0 ? 8'hFF : seg_tab[(j / 3) % 4]));
      end
      step(20);
      rst_b_n = 0;
      expect_at(cyc + 1, B_DIG, 64'hF);
      expect_at(cyc + 1, B_SEG, 64'hFF);
      step(1);
      rst_b_n = 1;
      r = cyc;
      for (int j = 0; j < 6; j++) begin
         expect_at(r + 1 + j, B_DIG, 64'(j % 3 == 0 ? 4'hF : dig_tab[j / 3]));
         expect_at(r + 1 + j, B_SEG, 64'(j % 3 == 0 ? 8'hFF : seg_tab[j / 3]));
      end
      step(10);
      checks++;
      if (sb.size() != 0 || pq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending exp 0/0", sb.size(), pq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
